// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - single-bullet launcher: spawn at tank muzzle, fly, explode, cool down.
module bullet_controller #(
    parameter int BULLET_SPEED    = 4,
    parameter int MUZZLE_OFFSET   = 12,
    parameter int BULLET_SIZE     = 2,
    parameter int MAX_RANGE       = 120,
    parameter int EXPLODE_FRAMES  = 8,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fire,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] TankDir,
    input  logic       bullet_collision,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic [9:0] Bullet_Size,
    output logic       bullet_active,
    output logic       explode,
    output logic [7:0] shots_fired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLYING,
        S_EXPLODE,
        S_COOLDOWN
    } state_t;

    localparam logic signed [10:0] OFFSET_STEP  = 11'(MUZZLE_OFFSET);
    localparam logic signed [10:0] SPEED_STEP   = 11'(BULLET_SPEED);
    localparam logic [9:0]         X_LIMIT      = 10'(X_MAX);
    localparam logic [9:0]         Y_LIMIT      = 10'(Y_MAX);
    localparam logic [7:0]         RANGE_LAST   = 8'(MAX_RANGE - 1);
    localparam logic [7:0]         EXPLODE_LAST = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0]         COOL_LAST    = 8'(COOLDOWN_FRAMES - 1);

    state_t     state, state_n;
    logic [1:0] dir_q, dir_n;
    logic [9:0] pos_x_q, pos_x_n;
    logic [9:0] pos_y_q, pos_y_n;
    logic [7:0] range_q, range_n;
    logic [7:0] timer_q, timer_n;
    logic [7:0] shots_q, shots_n;
    logic       fire_prev;

    logic              fire_edge;
    logic signed [10:0] spawn_x, spawn_y, move_x, move_y;
    logic              spawn_oob, move_oob;

    // Horizontal component only moves for right (01) and left (11).
    function automatic logic signed [10:0] shift_x(input logic [9:0] p, input logic [1:0] d,
                                                    input logic signed [10:0] amt);
        case (d)
            2'b01:   shift_x = $signed({1'b0, p}) + amt;
            2'b11:   shift_x = $signed({1'b0, p}) - amt;
            default: shift_x = $signed({1'b0, p});
        endcase
    endfunction

    function automatic logic signed [10:0] shift_y(input logic [9:0] p, input logic [1:0] d,
                                                    input logic signed [10:0] amt);
        case (d)
            2'b00:   shift_y = $signed({1'b0, p}) - amt;
            2'b10:   shift_y = $signed({1'b0, p}) + amt;
            default: shift_y = $signed({1'b0, p});
        endcase
    endfunction

    // Negative results carry the sign bit; anything else is checked against the screen edge.
    function automatic logic off_screen(input logic signed [10:0] v, input logic [9:0] lim);
        off_screen = v[10] | (v[9:0] > lim);
    endfunction

    assign fire_edge = fire & ~fire_prev;
    assign spawn_x   = shift_x(TankX, TankDir, OFFSET_STEP);
    assign spawn_y   = shift_y(TankY, TankDir, OFFSET_STEP);
    assign move_x    = shift_x(pos_x_q, dir_q, SPEED_STEP);
    assign move_y    = shift_y(pos_y_q, dir_q, SPEED_STEP);
    assign spawn_oob = off_screen(spawn_x, X_LIMIT) | off_screen(spawn_y, Y_LIMIT);
    assign move_oob  = off_screen(move_x, X_LIMIT) | off_screen(move_y, Y_LIMIT);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            dir_q     <= 2'b00;
            pos_x_q   <= 10'd0;
            pos_y_q   <= 10'd0;
            range_q   <= 8'd0;
            timer_q   <= 8'd0;
            shots_q   <= 8'd0;
            fire_prev <= 1'b0;
        end else begin
            state     <= state_n;
            dir_q     <= dir_n;
            pos_x_q   <= pos_x_n;
            pos_y_q   <= pos_y_n;
            range_q   <= range_n;
            timer_q   <= timer_n;
            shots_q   <= shots_n;
            fire_prev <= fire;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        pos_x_n = pos_x_q;
        pos_y_n = pos_y_q;
        range_n = range_q;
        timer_n = timer_q;
        shots_n = shots_q;
        case (state)
            S_IDLE: begin
                if (fire_edge) begin
                    shots_n = shots_q + 8'd1;
                    dir_n   = TankDir;
                    range_n = 8'd0;
                    timer_n = 8'd0;
                    if (spawn_oob) begin
                        state_n = S_COOLDOWN;
                    end else begin
                        state_n = S_FLYING;
                        pos_x_n = spawn_x[9:0];
                        pos_y_n = spawn_y[9:0];
                    end
                end
            end
            S_FLYING: begin
                if (bullet_collision) begin
                    state_n = S_EXPLODE;
                    timer_n = 8'd0;
                end else if (move_oob || range_q == RANGE_LAST) begin
                    state_n = S_COOLDOWN;
                    timer_n = 8'd0;
                end else begin
                    pos_x_n = move_x[9:0];
                    pos_y_n = move_y[9:0];
                    range_n = range_q + 8'd1;
                end
            end
            S_EXPLODE: begin
                if (timer_q == EXPLODE_LAST) begin
                    state_n = S_COOLDOWN;
                    timer_n = 8'd0;
                end else begin
                    timer_n = timer_q + 8'd1;
                end
            end
            S_COOLDOWN: begin
                if (timer_q == COOL_LAST) begin
                    state_n = S_IDLE;
                    timer_n = 8'd0;
                end else begin
                    timer_n = timer_q + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Position is only visible while a bullet or its explosion is on screen.
    assign BulletX       = (state == S_FLYING || state == S_EXPLODE) ? pos_x_q : 10'd0;
    assign BulletY       = (state == S_FLYING || state == S_EXPLODE) ? pos_y_q : 10'd0;
    assign Bullet_Size   = 10'(BULLET_SIZE);
    assign bullet_active = (state == S_FLYING);
    assign explode       = (state == S_EXPLODE);
    assign shots_fired   = shots_q;

endmodule

// File: tb/tb_bullet_controller.sv
// tb/tb_bullet_controller.sv - scenario and randomized checks of bullet_controller against a frame-level model.
module tb_bullet_controller;

    logic       frame_clk;
    logic       Reset;
    logic       fire;
    logic [9:0] TankX, TankY;
    logic [1:0] TankDir;
    logic       bullet_collision;
    logic [9:0] BulletX, BulletY, Bullet_Size;
    logic       bullet_active, explode;
    logic [7:0] shots_fired;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int M_IDLE = 0, M_FLY = 1, M_BOOM = 2, M_COOL = 3;
    int m_mode, m_left, m_flown, m_x, m_y, m_dx, m_dy, m_shots;
    bit m_prev;

    bullet_controller dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .fire(fire),
        .TankX(TankX),
        .TankY(TankY),
        .TankDir(TankDir),
        .bullet_collision(bullet_collision),
        .BulletX(BulletX),
        .BulletY(BulletY),
        .Bullet_Size(Bullet_Size),
        .bullet_active(bullet_active),
        .explode(explode),
        .shots_fired(shots_fired)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic bit off_screen(int x, int y);
        return (x < 0) || (x > 639) || (y < 0) || (y > 479);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_flown = 0; m_x = 0; m_y = 0;
        m_dx = 0; m_dy = 0; m_shots = 0; m_prev = 0;
    endtask

    // One video frame of the game rules, expressed as frames remaining / frames flown.
    task automatic model_step();
        bit edge_seen;
        int tx, ty, nx, ny;
        edge_seen = fire && !m_prev;
        tx = TankX;
        ty = TankY;
        case (m_mode)
            M_IDLE: if (edge_seen) begin
                m_shots = (m_shots + 1) % 256;
                m_dx = (TankDir == 2'd1) ? 1 : (TankDir == 2'd3) ? -1 : 0;
                m_dy = (TankDir == 2'd2) ? 1 : (TankDir == 2'd0) ? -1 : 0;
                nx = tx + 12 * m_dx;
                ny = ty + 12 * m_dy;
                if (off_screen(nx, ny)) begin
                    m_mode = M_COOL; m_left = 30;
                end else begin
                    m_mode = M_FLY; m_x = nx; m_y = ny; m_flown = 1;
                end
            end
            M_FLY: begin
                nx = m_x + 4 * m_dx;
                ny = m_y + 4 * m_dy;
                if (bullet_collision) begin
                    m_mode = M_BOOM; m_left = 8;
                end else if (off_screen(nx, ny) || m_flown == 120) begin
                    m_mode = M_COOL; m_left = 30;
                end else begin
                    m_x = nx; m_y = ny; m_flown++;
                end
            end
            M_BOOM: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_COOL; m_left = 30; end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
        m_prev = fire;
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        fire = 1'b0;
        bullet_collision = 1'b0;
        model_reset();
        #12;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        fire = 1'b1;
        bullet_collision = 1'b1;
        TankX = 10'd320; TankY = 10'd240; TankDir = 2'd1;
        model_reset();
        #3;
        n_cmp++;
        if (BulletX !== 10'd0 || BulletY !== 10'd0 || bullet_active !== 1'b0 || explode !== 1'b0 || shots_fired !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d act=%b exp=%b shots=%0d, expected all zero",
                     BulletX, BulletY, bullet_active, explode, shots_fired);
        end
        n_cmp++;
        if (Bullet_Size !== 10'd2) begin
            n_bad++;
            $display("FAIL bullet_size: got %0d expected 2", Bullet_Size);
        end
        #9;
        fire = 1'b0;
        bullet_collision = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_fire_right();
        apply_reset();
        TankX = 10'd320; TankY = 10'd240; TankDir = 2'd1;
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd332 || BulletY !== 10'd240 || shots_fired !== 8'd1) begin
            n_bad++;
            $display("FAIL fire_spawn: got act=%b (%0d,%0d) shots=%0d expected act=1 (332,240) shots=1",
                     bullet_active, BulletX, BulletY, shots_fired);
        end
        fire = 1'b0;
        TankDir = 2'd0;
        repeat (3) tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd344 || BulletY !== 10'd240) begin
            n_bad++;
            $display("FAIL fire_move: got act=%b (%0d,%0d) expected act=1 (344,240)",
                     bullet_active, BulletX, BulletY);
        end
    endtask

    task automatic test_collision();
        int n_boom;
        apply_reset();
        TankX = 10'd388; TankY = 10'd240; TankDir = 2'd1;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        bullet_collision = 1'b1;
        tick();
        n_cmp++;
        if (explode !== 1'b1 || bullet_active !== 1'b0 || BulletX !== 10'd400 || BulletY !== 10'd240) begin
            n_bad++;
            $display("FAIL collide_hold: got exp=%b act=%b (%0d,%0d) expected exp=1 act=0 (400,240)",
                     explode, bullet_active, BulletX, BulletY);
        end
        n_boom = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!explode) break;
            n_boom++;
        end
        bullet_collision = 1'b0;
        n_cmp++;
        if (n_boom != 8) begin
            n_bad++;
            $display("FAIL explode_len: got %0d frames expected 8", n_boom);
        end
        repeat (29) tick();
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b0 || BulletX !== 10'd0) begin
            n_bad++;
            $display("FAIL cooldown_len: got act=%b x=%0d expected act=0 x=0 (edge inside cooldown)", bullet_active, BulletX);
        end
        tick();
        n_cmp++;
        if (bullet_active !== 1'b0) begin
            n_bad++;
            $display("FAIL held_fire_after_cooldown: got act=%b expected 0", bullet_active);
        end
        fire = 1'b0;
        tick();
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd400 || shots_fired !== 8'd2) begin
            n_bad++;
            $display("FAIL refire_after_cooldown: got act=%b x=%0d shots=%0d expected act=1 x=400 shots=2",
                     bullet_active, BulletX, shots_fired);
        end
        fire = 1'b0;
    endtask

    task automatic test_underflow();
        bit seen;
        apply_reset();
        TankX = 10'd5; TankY = 10'd100; TankDir = 2'd3;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        n_cmp++;
        if (bullet_active !== 1'b0 || BulletX !== 10'd0 || shots_fired !== 8'd1) begin
            n_bad++;
            $display("FAIL underflow_spawn: got act=%b x=%0d shots=%0d expected act=0 x=0 shots=1",
                     bullet_active, BulletX, shots_fired);
        end
        seen = 0;
        repeat (30) begin
            tick();
            if (bullet_active || explode) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL underflow_never_active: got active/explode seen=1 expected 0");
        end
    endtask

    task automatic test_edge_bound();
        bit seen;
        apply_reset();
        TankX = 10'd625; TankY = 10'd50; TankDir = 2'd1;
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd637 || BulletY !== 10'd50) begin
            n_bad++;
            $display("FAIL edge_spawn: got act=%b (%0d,%0d) expected act=1 (637,50)", bullet_active, BulletX, BulletY);
        end
        tick();
        n_cmp++;
        if (bullet_active !== 1'b0 || explode !== 1'b0 || BulletX !== 10'd0) begin
            n_bad++;
            $display("FAIL edge_exit: got act=%b exp=%b x=%0d expected 0 0 0", bullet_active, explode, BulletX);
        end
        bullet_collision = 1'b1;
        seen = 0;
        repeat (33) begin
            tick();
            if (bullet_active || explode) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL edge_held_inputs: got active/explode seen=1 expected 0");
        end
        bullet_collision = 1'b0;
        fire = 1'b0;
        tick();
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd637 || shots_fired !== 8'd2) begin
            n_bad++;
            $display("FAIL edge_refire: got act=%b x=%0d shots=%0d expected 1 637 2", bullet_active, BulletX, shots_fired);
        end
        fire = 1'b0;
    endtask

    task automatic test_range();
        int flights, last_x;
        apply_reset();
        TankX = 10'd100; TankY = 10'd240; TankDir = 2'd1;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        flights = 0;
        last_x = 0;
        for (int i = 0; i < 200 && bullet_active; i++) begin
            flights++;
            last_x = BulletX;
            tick();
        end
        n_cmp++;
        if (flights != 120 || last_x != 588) begin
            n_bad++;
            $display("FAIL range_limit: got %0d frames last_x=%0d expected 120 frames last_x=588", flights, last_x);
        end
        n_cmp++;
        if (explode !== 1'b0 || BulletX !== 10'd0) begin
            n_bad++;
            $display("FAIL range_end_state: got exp=%b x=%0d expected 0 0", explode, BulletX);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        TankX = 10'd5; TankY = 10'd100; TankDir = 2'd3;
        for (int i = 1; i <= 256; i++) begin
            fire = 1'b1;
            tick();
            fire = 1'b0;
            repeat (30) tick();
            if (i == 255) begin
                n_cmp++;
                if (shots_fired !== 8'd255) begin
                    n_bad++;
                    $display("FAIL shots_255: got %0d expected 255", shots_fired);
                end
            end
        end
        n_cmp++;
        if (shots_fired !== 8'd0) begin
            n_bad++;
            $display("FAIL shots_wrap: got %0d expected 0", shots_fired);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        TankX = 10'd320; TankY = 10'd240; TankDir = 2'd1;
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if (BulletX !== 10'd0 || BulletY !== 10'd0 || bullet_active !== 1'b0 || explode !== 1'b0 || shots_fired !== 8'd0) begin
            n_bad++;
            $display("FAIL async_reset_flight: got x=%0d y=%0d act=%b exp=%b shots=%0d expected all zero",
                     BulletX, BulletY, bullet_active, explode, shots_fired);
        end
        #10;
        Reset = 1'b0;
        tick();
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd332 || shots_fired !== 8'd1) begin
            n_bad++;
            $display("FAIL fire_after_reset: got act=%b x=%0d shots=%0d expected 1 332 1", bullet_active, BulletX, shots_fired);
        end
        fire = 1'b0;
        apply_reset();
        TankX = 10'd5; TankDir = 2'd3;
        fire = 1'b1;
        tick();
        apply_reset();
        TankX = 10'd320; TankDir = 2'd1;
        tick();
        fire = 1'b1;
        tick();
        n_cmp++;
        if (bullet_active !== 1'b1 || BulletX !== 10'd332) begin
            n_bad++;
            $display("FAIL fire_after_cooldown_reset: got act=%b x=%0d expected 1 332", bullet_active, BulletX);
        end
        fire = 1'b0;
    endtask

    task automatic test_random();
        int ex, ey;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) fire = ~fire;
            bullet_collision = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) TankDir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                TankX = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 639));
                TankY = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(464, 479)) : 10'($urandom_range(0, 479));
            end
            tick();
            ex = (m_mode == M_FLY || m_mode == M_BOOM) ? m_x : 0;
            ey = (m_mode == M_FLY || m_mode == M_BOOM) ? m_y : 0;
            n_cmp++;
            if (BulletX !== ex[9:0] || BulletY !== ey[9:0]) begin
                n_bad++;
                $display("FAIL rand_pos cyc %0d: got (%0d,%0d) expected (%0d,%0d)", c, BulletX, BulletY, ex, ey);
            end
            n_cmp++;
            if (bullet_active !== (m_mode == M_FLY) || explode !== (m_mode == M_BOOM)) begin
                n_bad++;
                $display("FAIL rand_flags cyc %0d: got act=%b exp=%b expected act=%0d exp=%0d",
                         c, bullet_active, explode, m_mode == M_FLY, m_mode == M_BOOM);
            end
            n_cmp++;
            if (shots_fired !== m_shots[7:0]) begin
                n_bad++;
                $display("FAIL rand_shots cyc %0d: got %0d expected %0d", c, shots_fired, m_shots);
            end
        end
        fire = 1'b0;
        bullet_collision = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fire_right();
        test_collision();
        test_underflow();
        test_edge_bound();
        test_range();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
